// File: rtl/sort_result_checker.sv
// Post-sort checker: streams the 256-word sorted memory once and reports
// ordering, first violation, min/max/median and adjacent-duplicate count.
module sort_result_checker #(
  parameter int DW = 16,
  parameter int AW = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  output logic          o_memRd,
  output logic [AW-1:0] o_memAddr,
  input  logic [DW-1:0] i_memData,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_sortedOk,
  output logic [AW-1:0] o_errAddr,
  output logic [DW-1:0] o_minVal,
  output logic [DW-1:0] o_maxVal,
  output logic [DW-1:0] o_medianVal,
  output logic [AW-1:0] o_dupCount
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SCAN  = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;

  localparam logic [AW-1:0] LAST_ADDR = {AW{1'b1}};
  localparam logic [AW-1:0] MED_LO    = AW'((1 << AW) / 2 - 1);
  localparam logic [AW-1:0] MED_HI    = AW'((1 << AW) / 2);

  logic [1:0]    r_state;
  logic          r_memRd;
  logic [AW-1:0] r_memAddr;
  logic          r_done;
  logic          r_dataVld;
  logic [AW-1:0] r_dataTag;
  logic [DW-1:0] r_prev;
  logic [DW-1:0] r_medLo;
  logic          r_sortedOk;
  logic [AW-1:0] r_errAddr;
  logic [DW-1:0] r_minVal;
  logic [DW-1:0] r_maxVal;
  logic [DW-1:0] r_medianVal;
  logic [AW-1:0] r_dupCount;
  logic [DW:0]   w_medSum;

  // One extra bit keeps the midpoint sum from wrapping for 0xFFFF inputs.
  assign w_medSum = {1'b0, r_medLo} + {1'b0, i_memData};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_memRd     <= 1'b0;
      r_memAddr   <= '0;
      r_done      <= 1'b0;
      r_dataVld   <= 1'b0;
      r_dataTag   <= '0;
      r_prev      <= '0;
      r_medLo     <= '0;
      r_sortedOk  <= 1'b0;
      r_errAddr   <= '0;
      r_minVal    <= '0;
      r_maxVal    <= '0;
      r_medianVal <= '0;
      r_dupCount  <= '0;
    end else begin
      r_done    <= 1'b0;
      // Read data lags the address by one cycle, so tag it with the delayed address.
      r_dataVld <= r_memRd;
      r_dataTag <= r_memAddr;

      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_state     <= SCAN;
            r_memRd     <= 1'b1;
            r_memAddr   <= '0;
            r_prev      <= '0;
            r_medLo     <= '0;
            r_sortedOk  <= 1'b1;
            r_errAddr   <= '0;
            r_minVal    <= '0;
            r_maxVal    <= '0;
            r_medianVal <= '0;
            r_dupCount  <= '0;
          end
        end
        SCAN: begin
          if (r_memAddr == LAST_ADDR) begin
            r_state <= FLUSH;
            r_memRd <= 1'b0;
          end else begin
            r_memAddr <= r_memAddr + 1'b1;
          end
        end
        FLUSH: begin
          r_state <= IDLE;
          r_done  <= 1'b1;
        end
        default: begin
          r_state <= IDLE;
          r_memRd <= 1'b0;
        end
      endcase

      if (r_dataVld) begin
        r_prev <= i_memData;
        if (r_dataTag == '0) begin
          r_minVal <= i_memData;
        end else begin
          if (i_memData < r_prev && r_sortedOk) begin
            r_sortedOk <= 1'b0;
            r_errAddr  <= r_dataTag;
          end
          if (i_memData == r_prev) begin
            r_dupCount <= r_dupCount + 1'b1;
          end
        end
        if (r_dataTag == MED_LO) begin
          r_medLo <= i_memData;
        end
        if (r_dataTag == MED_HI) begin
          r_medianVal <= w_medSum[DW:1];
        end
        if (r_dataTag == LAST_ADDR) begin
          r_maxVal <= i_memData;
        end
      end
    end
  end

  assign o_memRd     = r_memRd;
  assign o_memAddr   = r_memAddr;
  assign o_busy      = (r_state != IDLE);
  assign o_done      = r_done;
  assign o_sortedOk  = r_sortedOk;
  assign o_errAddr   = r_errAddr;
  assign o_minVal    = r_minVal;
  assign o_maxVal    = r_maxVal;
  assign o_medianVal = r_medianVal;
  assign o_dupCount  = r_dupCount;

endmodule
